// File: rtl/npu_sram_pkg.sv
// Shared definitions for the activation/weight SRAM read path:
// geometry of the 128b x 4096 read port and the streamer state encoding.
package npu_sram_pkg;

  localparam int SRAM_DATA_W = 128;
  localparam int SRAM_ADDR_W = 12;
  localparam int SRAM_DEPTH  = 1 << SRAM_ADDR_W;

  typedef enum logic [1:0] {
    IDLE,
    RUN,
    DRAIN
  } stream_state_e;

endpackage

// File: rtl/sync_fifo.sv
// Single-clock FIFO with occupancy count; head word is visible combinationally
// on rdata_o whenever the FIFO is not empty. DEPTH must be a power of two.
module sync_fifo #(
  parameter int WIDTH = 8,
  parameter int DEPTH = 4
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     push_i,
  input  logic [WIDTH-1:0]         wdata_i,
  input  logic                     pop_i,
  output logic [WIDTH-1:0]         rdata_o,
  output logic                     empty_o,
  output logic [$clog2(DEPTH):0]   count_o
);

  localparam int PTR_W = $clog2(DEPTH);

  logic [WIDTH-1:0] mem_q [DEPTH];
  logic [PTR_W-1:0] wptr_q, rptr_q;
  logic [PTR_W:0]   count_q;
  logic             full, do_push, do_pop;

  assign empty_o = (count_q == '0);
  assign full    = (count_q == (PTR_W+1)'(DEPTH));
  assign do_pop  = pop_i && !empty_o;
  // A pop in the same cycle frees the slot a push into a full FIFO needs.
  assign do_push = push_i && (!full || do_pop);
  assign rdata_o = mem_q[rptr_q];
  assign count_o = count_q;

  always_ff @(posedge clk) begin
    if (do_push) mem_q[wptr_q] <= wdata_i;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wptr_q  <= '0;
      rptr_q  <= '0;
      count_q <= '0;
    end else begin
      if (do_push) wptr_q <= wptr_q + PTR_W'(1);
      if (do_pop)  rptr_q <= rptr_q + PTR_W'(1);
      case ({do_push, do_pop})
        2'b10:   count_q <= count_q + (PTR_W+1)'(1);
        2'b01:   count_q <= count_q - (PTR_W+1)'(1);
        default: ;
      endcase
    end
  end

endmodule

// File: rtl/sram_read_streamer.sv
// Burst reader for the SRAM read port: issues reads under a credit limit, absorbs
// the 1-cycle read latency and delivers words as a valid/ready stream.
module sram_read_streamer
  import npu_sram_pkg::*;
#(
  parameter int DATA_W     = SRAM_DATA_W,
  parameter int ADDR_W     = SRAM_ADDR_W,
  parameter int LEN_W      = 13,
  parameter int FIFO_DEPTH = 4
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              cmd_valid,
  output logic              cmd_ready,
  input  logic [ADDR_W-1:0] cmd_addr,
  input  logic [LEN_W-1:0]  cmd_len,
  output logic              sram_enb,
  output logic [ADDR_W-1:0] sram_addrb,
  input  logic [DATA_W-1:0] sram_doutb,
  output logic              out_valid,
  input  logic              out_ready,
  output logic [DATA_W-1:0] out_data,
  output logic              out_last,
  output logic              busy,
  output logic              done
);

  localparam int                CNT_W   = $clog2(FIFO_DEPTH) + 1;
  localparam logic [CNT_W:0]    DEPTH_C = (CNT_W+1)'(FIFO_DEPTH);

  stream_state_e     state_q;
  logic [ADDR_W-1:0] rd_addr_q;
  logic [LEN_W-1:0]  issue_cnt_q, beat_cnt_q;
  logic              inflight_q, inflight_last_q, done_q;

  logic [CNT_W-1:0]  fifo_cnt;
  logic              fifo_empty;
  logic [DATA_W:0]   fifo_head;
  logic [CNT_W:0]    occ;
  logic              pop, credit_ok, issue, last_issue;

  assign cmd_ready = (state_q == IDLE);
  assign busy      = (state_q != IDLE);
  assign done      = done_q;

  assign out_valid = !fifo_empty;
  assign pop       = out_valid && out_ready;
  assign out_data  = out_valid ? fifo_head[DATA_W-1:0] : '0;
  assign out_last  = out_valid && fifo_head[DATA_W];

  // Slots already spoken for: buffered words plus the read whose data lands this cycle.
  assign occ        = {1'b0, fifo_cnt} + {{CNT_W{1'b0}}, inflight_q} - {{CNT_W{1'b0}}, pop};
  assign credit_ok  = (occ < DEPTH_C);
  assign issue      = (state_q == RUN) && (issue_cnt_q != '0) && credit_ok;
  assign last_issue = issue && (issue_cnt_q == LEN_W'(1));

  assign sram_enb   = issue;
  assign sram_addrb = issue ? rd_addr_q : '0;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q         <= IDLE;
      rd_addr_q       <= '0;
      issue_cnt_q     <= '0;
      beat_cnt_q      <= '0;
      inflight_q      <= 1'b0;
      inflight_last_q <= 1'b0;
      done_q          <= 1'b0;
    end else begin
      done_q          <= 1'b0;
      inflight_q      <= issue;
      inflight_last_q <= last_issue;
      case (state_q)
        IDLE: begin
          if (cmd_valid) begin
            if (cmd_len != '0) begin
              state_q     <= RUN;
              rd_addr_q   <= cmd_addr;
              issue_cnt_q <= cmd_len;
              beat_cnt_q  <= cmd_len;
            end else begin
              done_q <= 1'b1;
            end
          end
        end
        RUN: begin
          if (issue) begin
            rd_addr_q   <= rd_addr_q + ADDR_W'(1);
            issue_cnt_q <= issue_cnt_q - LEN_W'(1);
          end
          if (pop) beat_cnt_q <= beat_cnt_q - LEN_W'(1);
          if (last_issue) state_q <= DRAIN;
        end
        DRAIN: begin
          if (pop) begin
            beat_cnt_q <= beat_cnt_q - LEN_W'(1);
            if (out_last) begin
              state_q <= IDLE;
              done_q  <= 1'b1;
            end
          end
        end
        default: state_q <= IDLE;
      endcase
    end
  end

  sync_fifo #(
    .WIDTH (DATA_W + 1),
    .DEPTH (FIFO_DEPTH)
  ) u_fifo (
    .clk     (clk),
    .rst     (rst),
    .push_i  (inflight_q),
    .wdata_i ({inflight_last_q, sram_doutb}),
    .pop_i   (pop),
    .rdata_o (fifo_head),
    .empty_o (fifo_empty),
    .count_o (fifo_cnt)
  );

endmodule
